// File: rtl/fir_seq_pkg.sv
// Shared widths, FSM encoding, reset coefficients and helpers for the FIR MAC sequencer.
package fir_seq_pkg;

  localparam int unsigned NTAPS  = 4;
  localparam int unsigned SAMP_W = 4;
  localparam int unsigned COEF_W = 4;
  localparam int unsigned MAG_W  = 4;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned Y_W    = 8;
  localparam int unsigned CNT_W  = $clog2(NTAPS);

  typedef logic signed [SAMP_W-1:0] samp_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [Y_W-1:0]    y_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic sat;
    y_t   y;
  } res_t;

  // Element [0] is tap 0.
  localparam coef_t [NTAPS-1:0] COEF_RST = {coef_t'(1), coef_t'(2), coef_t'(2), coef_t'(1)};

  localparam acc_t ACC_YMAX = acc_t'(127);
  localparam acc_t ACC_YMIN = acc_t'(-128);

  // Two's-complement magnitude; -8 maps to 4'b1000 (8) which fits unsigned.
  function automatic logic [MAG_W-1:0] mag4(input logic [MAG_W-1:0] v);
    return v[MAG_W-1] ? MAG_W'(~v + MAG_W'(1)) : v;
  endfunction

  function automatic res_t sat8(input acc_t a);
    res_t r;
    r.sat = (a > ACC_YMAX) || (a < ACC_YMIN);
    if (a > ACC_YMAX)      r.y = y_t'(ACC_YMAX);
    else if (a < ACC_YMIN) r.y = y_t'(ACC_YMIN);
    else                   r.y = y_t'(a);
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient-config and result handshake bundle for the FIR MAC sequencer.
interface fir_mac_sequencer_if;
  import fir_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  samp_t            x;
  logic             cfg_we;
  logic [CNT_W-1:0] cfg_addr;
  coef_t            cfg_data;
  logic             out_valid;
  logic             out_ready;
  y_t               y;
  logic             sat;
  logic             busy;

  modport master (
    output in_valid, x, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, out_valid, y, sat, busy
  );

  modport slave (
    input  in_valid, x, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, out_valid, y, sat, busy
  );
endinterface

// File: rtl/fir_mac_sequencer_vedic_mul4.sv
// Combinational 4x4 unsigned Vedic (Urdhva Tiryagbhyam) multiplier built from 2x2 blocks.
module vedic_mul4
  import fir_seq_pkg::*;
(
  input  logic [MAG_W-1:0]  a,
  input  logic [MAG_W-1:0]  b,
  output logic [PROD_W-1:0] p_c
);

  function automatic logic [3:0] mul2(input logic [1:0] u, input logic [1:0] v);
    logic [3:0] q;
    logic       c1;
    q[0] = u[0] & v[0];
    q[1] = (u[1] & v[0]) ^ (u[0] & v[1]);
    c1   = (u[1] & v[0]) & (u[0] & v[1]);
    q[2] = (u[1] & v[1]) ^ c1;
    q[3] = (u[1] & v[1]) & c1;
    return q;
  endfunction

  logic [3:0] pp_ll, pp_lh, pp_hl, pp_hh;

  assign pp_ll = mul2(a[1:0], b[1:0]);
  assign pp_lh = mul2(a[1:0], b[3:2]);
  assign pp_hl = mul2(a[3:2], b[1:0]);
  assign pp_hh = mul2(a[3:2], b[3:2]);

  // Crosswise partials carry weight 4, the high vertical partial weight 16.
  assign p_c = PROD_W'(pp_ll)
             + (PROD_W'(pp_lh) << 2)
             + (PROD_W'(pp_hl) << 2)
             + (PROD_W'(pp_hh) << 4);

endmodule

// File: rtl/fir_mac_sequencer.sv
// 4-tap FIR filter computed one tap per cycle on a single shared multiplier,
// with valid/ready sample input, saturating result output and IDLE-only coefficient writes.
module fir_mac_sequencer #(
  parameter int unsigned NTAPS = fir_seq_pkg::NTAPS
) (
  input logic               clk,
  input logic               rst,
  fir_mac_sequencer_if.slave bus
);
  import fir_seq_pkg::*;

  state_t             state_q, state_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  acc_t               acc_q, acc_nx;
  res_t               res_q, res_nx;
  logic               ov_q, ov_nx;
  samp_t [NTAPS-1:0]  d_q, d_nx;
  coef_t [NTAPS-1:0]  coef_q, coef_nx;
  logic               in_ready_q, in_ready_nx;
  logic               busy_q, busy_nx;

  coef_t              cur_coef;
  samp_t              cur_d;
  logic [MAG_W-1:0]   mag_coef, mag_d;
  logic [PROD_W-1:0]  prod_u;
  logic               neg;
  prod_t              prod;
  acc_t               sum;

  // Sign-magnitude multiply: unsigned core, sign reapplied afterwards.
  assign cur_coef = coef_q[cnt_q];
  assign cur_d    = d_q[cnt_q];
  assign mag_coef = mag4(cur_coef);
  assign mag_d    = mag4(cur_d);
  assign neg      = cur_coef[COEF_W-1] ^ cur_d[SAMP_W-1];

  vedic_mul4 u_mul (
    .a   (mag_coef),
    .b   (mag_d),
    .p_c (prod_u)
  );

  assign prod = neg ? prod_t'(~prod_u + PROD_W'(1)) : prod_t'(prod_u);
  assign sum  = acc_q + acc_t'(prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      ov_q       <= 1'b0;
      d_q        <= '0;
      coef_q     <= COEF_RST;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      acc_q      <= acc_nx;
      res_q      <= res_nx;
      ov_q       <= ov_nx;
      d_q        <= d_nx;
      coef_q     <= coef_nx;
      in_ready_q <= in_ready_nx;
      busy_q     <= busy_nx;
    end
  end

  always_comb begin
    state_nx    = state_q;
    cnt_nx      = cnt_q;
    acc_nx      = acc_q;
    res_nx      = res_q;
    ov_nx       = ov_q;
    d_nx        = d_q;
    coef_nx     = coef_q;
    in_ready_nx = in_ready_q;
    busy_nx     = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        // A same-cycle write is visible to the sample accepted alongside it.
        if (bus.cfg_we) coef_nx[bus.cfg_addr] = bus.cfg_data;
        if (bus.in_valid && in_ready_q) begin
          d_nx     = {d_q[NTAPS-2:0], bus.x};
          cnt_nx   = '0;
          acc_nx   = '0;
          state_nx = ST_MAC;
        end
      end
      ST_MAC: begin
        if (cnt_q == CNT_W'(NTAPS-1)) begin
          res_nx   = sat8(sum);
          ov_nx    = 1'b1;
          state_nx = ST_OUT;
        end else begin
          acc_nx = sum;
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          ov_nx    = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    in_ready_nx = (state_nx == ST_IDLE);
    busy_nx     = (state_nx != ST_IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = ov_q;
  assign bus.y         = res_q.y;
  assign bus.sat       = res_q.sat;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench: directed cases plus randomized samples/config against a tap-sum model.
module tb_fir_mac_sequencer;
  import fir_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   mcoef[4];
  int   md[4];

  fir_mac_sequencer_if bus();

  fir_mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_result(output int ey, output int es);
    int s = 0;
    for (int k = 0; k < 4; k++) s += mcoef[k] * md[k];
    ey = s;
    es = 0;
    if (s > 127) begin
      ey = 127;
      es = 1;
    end else if (s < -128) begin
      ey = -128;
      es = 1;
    end
  endtask

  task automatic do_reset(input string tag);
    bus.in_valid  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    #2;
    chk({tag, "_in_ready"},  int'(bus.in_ready), 1);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_y"},         int'(bus.y), 0);
    chk({tag, "_sat"},       int'(bus.sat), 0);
    chk({tag, "_busy"},      int'(bus.busy), 0);
    step();
    step();
    rst = 1'b1;
    mcoef = '{1, 2, 2, 1};
    md    = '{0, 0, 0, 0};
  endtask

  task automatic cfg_write(input int ca, input int cd);
    int n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    chk("cfg_idle", int'(bus.in_ready), 1);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'(ca);
    bus.cfg_data = coef_t'(cd);
    step();
    bus.cfg_we = 1'b0;
    mcoef[ca] = cd;
  endtask

  task automatic do_sample(input int xv, input int hold, input bit idle_we, input bit mac_we,
                           input int ca, input int cd, output int gy, output int gs);
    int n, ey, es;
    n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    chk("accept_ready", int'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.x         = samp_t'(xv);
    bus.out_ready = (hold == 0);
    if (idle_we) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'(ca);
      bus.cfg_data = coef_t'(cd);
      mcoef[ca]    = cd;
    end
    step();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    for (int k = 3; k > 0; k--) md[k] = md[k-1];
    md[0] = xv;
    model_result(ey, es);
    chk("mac_busy",  int'(bus.busy), 1);
    chk("mac_ready", int'(bus.in_ready), 0);
    if (mac_we) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'(ca);
      bus.cfg_data = coef_t'(cd);
    end
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      bus.cfg_we = 1'b0;
      n++;
    end
    chk("latency", n, 4);
    gy = int'(bus.y);
    gs = int'(bus.sat);
    chk("y", gy, ey);
    chk("sat", gs, es);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.x        = samp_t'($urandom_range(0, 15));
      step();
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_y",     int'(bus.y), ey);
      chk("hold_sat",   int'(bus.sat), es);
      chk("hold_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("handshake_valid", int'(bus.out_valid), 0);
    chk("handshake_ready", int'(bus.in_ready), 1);
    chk("handshake_busy",  int'(bus.busy), 0);
  endtask

  initial begin
    int gy, gs, seen;
    int exp030[4] = '{1, 4, 9, 15};

    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.out_ready = 1'b1;
    #3;
    do_reset("rst0");

    // Default coefficients, ramp input.
    for (int i = 0; i < 4; i++) begin
      do_sample(i + 1, 0, 1'b0, 1'b0, 0, 0, gy, gs);
      chk($sformatf("ramp_y%0d", i), gy, exp030[i]);
      chk($sformatf("ramp_sat%0d", i), gs, 0);
    end

    // Coefficient write during MAC is dropped; IDLE write with accept applies.
    do_reset("rst1");
    do_sample(1, 0, 1'b0, 1'b1, 0, 5, gy, gs);
    chk("macwr_cur", gy, 1);
    do_sample(1, 0, 1'b0, 1'b0, 0, 0, gy, gs);
    chk("macwr_next", gy, 3);
    do_reset("rst2");
    do_sample(1, 0, 1'b1, 1'b0, 0, 5, gy, gs);
    chk("idlewr_y", gy, 5);

    // Reset in the middle of a MAC run.
    do_reset("rst3");
    bus.in_valid = 1'b1;
    bus.x        = samp_t'(5);
    step();
    bus.in_valid = 1'b0;
    step();
    do_reset("rst_mac");
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("no_stale_valid", seen, 0);
    do_sample(3, 0, 1'b0, 1'b0, 0, 0, gy, gs);
    chk("after_rst_y", gy, 3);

    // Saturation at both rails.
    for (int k = 0; k < 4; k++) cfg_write(k, -8);
    for (int i = 0; i < 4; i++) do_sample(-8, 0, 1'b0, 1'b0, 0, 0, gy, gs);
    chk("satpos_y", gy, 127);
    chk("satpos_sat", gs, 1);
    for (int k = 0; k < 4; k++) cfg_write(k, 7);
    for (int i = 0; i < 4; i++) do_sample(-8, 0, 1'b0, 1'b0, 0, 0, gy, gs);
    chk("satneg_y", gy, -128);
    chk("satneg_sat", gs, 1);

    // Back-pressure: consumer stalls ten cycles.
    do_sample(2, 10, 1'b0, 1'b0, 0, 0, gy, gs);

    // Randomized samples, config writes and stalls.
    do_reset("rst4");
    for (int it = 0; it < 60; it++) begin
      int xv, hold, ca, cd;
      bit iw, mw;
      xv   = int'($urandom_range(0, 15)) - 8;
      hold = int'($urandom_range(0, 3));
      ca   = int'($urandom_range(0, 3));
      cd   = int'($urandom_range(0, 15)) - 8;
      iw   = ($urandom_range(0, 3) == 0);
      mw   = !iw && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0)
        cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)) - 8);
      do_sample(xv, hold, iw, mw, ca, cd, gy, gs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter: NTAPS, 4, number of FIR taps; only 4 is supported.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  in  1  sample x offered.
REQ-005 Port: in_ready  out  1  sequencer can accept a sample.
REQ-006 Port: x  in  4  signed input sample.
REQ-007 Port: cfg_we  in  1  coefficient write strobe.
REQ-008 Port: cfg_addr  in  2  tap index 0..3.
REQ-009 Port: cfg_data  in  4  signed coefficient value.
REQ-010 Port: out_valid  out  1  y holds a finished result.
REQ-011 Port: out_ready  in  1  consumer takes y.
REQ-012 Port: y  out  8  signed, saturated filter output.
REQ-013 Port: sat  out  1  y was clipped; qualified by out_valid.
REQ-014 Port: busy  out  1  high in states MAC and OUT.

Function
REQ-015 FSM states are IDLE, MAC and OUT; in_ready SHALL equal (state==IDLE).
REQ-016 IDLE to MAC on in_valid&in_ready: delay line shifts (d0<=x, dk<=dk-1), tap counter=0, accumulator=0.
REQ-017 MAC: one product coef[k]*d[k] per cycle via the single shared multiplier, accumulated for k=0..NTAPS-1.
REQ-018 On the last MAC edge: y<=sat8(acc+product), sat set if clipped, out_valid<=1, state to OUT; out_valid high exactly NTAPS cycles after the accept edge.
REQ-019 OUT: y, sat and out_valid held stable until out_valid&out_ready; then out_valid<=0, state to IDLE.
REQ-020 A new sample can be accepted no earlier than the cycle after the OUT handshake; in_valid is ignored in MAC/OUT.
REQ-021 Signed multiply: magnitudes (0..8) fed to unsigned 4x4 multiplier; product negated when operand signs differ; 8-bit signed product range -56..64.
REQ-022 Accumulator 10-bit signed; saturation to 8 bits: >127 gives 127, <-128 gives -128, sat=1; otherwise sat=0.
REQ-023 cfg_we takes effect only in IDLE; writes in MAC/OUT are dropped.
REQ-024 Simultaneous cfg_we and accept in IDLE: both occur; the accepted sample uses the new coefficient.

Reset
REQ-025 Async assert: state=IDLE, d0..d3=0, acc=0, counter=0, y=0, sat=0, out_valid=0, busy=0; in_ready=1.
REQ-026 Coefficients reset to tap0..3 = 1, 2, 2, 1.
REQ-027 Reset during MAC/OUT discards the partial result; no out_valid pulse follows.

Structure
REQ-028 Shared package fir_seq_pkg holds NTAPS, sample/coef/product/acc widths, FSM state encoding and default coefficients.
REQ-029 One sub-module, vedic_mul4 (combinational 4x4 unsigned Vedic multiplier, 8-bit product), instantiated exactly once.

Verification
REQ-030 Reset, then samples 1,2,3,4 with out_ready=1 -> y = 1, 4, 9, 15; sat=0; each out_valid exactly 4 cycles after accept.
REQ-031 All coefs -8, samples -8 x4 -> 4th y=127, sat=1; coefs 7, samples -8 x4 -> 4th y=-128, sat=1.
REQ-032 out_ready=0 for 10 cycles in OUT -> y/out_valid stable, in_ready=0, in_valid pulses ignored; result delivered once out_ready=1.
REQ-033 cfg_we (addr 0, data 5) in MAC -> dropped, current and next results use coef 1; same write in IDLE with accept of x=1 -> y=5.
REQ-034 Assert rst during MAC cycle 2 -> all outputs reset values, no out_valid; next sample 3 -> y=3.
